mfcc_var_acc: RTL and testbench

MFCC_VAR_ACC -- requirements
Module: mfcc_var_acc

---
 rtl/mfcc_var_acc.sv | 160 ++++++++++++++++
 tb/tb_mfcc_var_acc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mfcc_var_acc.sv
// Windowed variance of MFCC coefficients: accumulates 2^LOG2N samples, then computes E[x^2] - E[x]^2 in Q.10.
// Optional macro MIN_VAR_CLAMP_EN floors each result at 1.0 (1024) for the downstream inverse-sqrt stage.
module mfcc_var_acc #(
    parameter int IBIT  = 16,
    parameter int OBIT  = 32,
    parameter int LOG2N = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dv_i,
    input  logic [IBIT-1:0] x_i,
    output logic            ready_o,
    output logic            dv_o,
    output logic [OBIT-1:0] sq_o
);

    localparam int SW   = IBIT + LOG2N;
    localparam int QW   = 2 * IBIT + LOG2N;
    localparam int PW   = 2 * IBIT;
    localparam int FRAC = 10;

    typedef enum logic [2:0] {
        ACC,
        MEAN,
        SQ,
        SUB,
        OUT
    } state_t;

    state_t state_q, state_d;

    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [QW-1:0]    sumSq_q, sumSq_d;
    logic [IBIT-1:0]  mean_q, mean_d;
    logic [PW-1:0]    msqAvg_q, msqAvg_d;
    logic [PW-1:0]    msq_q, msq_d;
    logic [PW-1:0]    diff_q, diff_d;
    logic [OBIT-1:0]  sq_q, sq_d;
    logic             dv_q, dv_d;

    logic             accept;
    logic             lastSample;
    logic signed [PW-1:0] xSq;
    logic signed [PW-1:0] meanProd;
    logic [PW:0]      diffWide;
    logic [PW-1:0]    shifted;

    assign ready_o    = (state_q == ACC);
    assign accept     = dv_i && ready_o;
    assign lastSample = accept && (cnt_q == {LOG2N{1'b1}});

    // Squares are non-negative, so the signed products can be zero-extended into the accumulators.
    assign xSq      = $signed(x_i) * $signed(x_i);
    assign meanProd = $signed(mean_q) * $signed(mean_q);
    assign diffWide = {1'b0, msqAvg_q} - {1'b0, msq_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (lastSample) state_d = MEAN;
            MEAN:    state_d = SQ;
            SQ:      state_d = SUB;
            SUB:     state_d = OUT;
            OUT:     state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        sumSq_d  = sumSq_q;
        mean_d   = mean_q;
        msqAvg_d = msqAvg_q;
        msq_d    = msq_q;
        diff_d   = diff_q;
        sq_d     = sq_q;
        dv_d     = 1'b0;
        shifted  = diff_q >> FRAC;

        case (state_q)
            ACC: begin
                if (accept) begin
                    cnt_d   = cnt_q + LOG2N'(1);
                    sum_d   = sum_q + {{LOG2N{x_i[IBIT-1]}}, x_i};
                    sumSq_d = sumSq_q + {{LOG2N{1'b0}}, xSq};
                end
            end
            MEAN: begin
                // Dropping the low LOG2N bits of the signed sum is a floor division by N.
                mean_d   = sum_q[SW-1:LOG2N];
                msqAvg_d = sumSq_q[QW-1:LOG2N];
            end
            SQ: begin
                msq_d = meanProd;
            end
            SUB: begin
                // Floor rounding of the mean can make the difference dip slightly below zero.
                if (diffWide[PW]) begin
                    diff_d = '0;
                end else begin
                    diff_d = diffWide[PW-1:0];
                end
            end
            OUT: begin
`ifdef MIN_VAR_CLAMP_EN
                if (shifted < PW'(1024)) begin
                    shifted = PW'(1024);
                end
`else
                shifted = diff_q >> FRAC;
`endif
                sq_d    = OBIT'(shifted);
                dv_d    = 1'b1;
                sum_d   = '0;
                sumSq_d = '0;
            end
            default: begin
                dv_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sum_q    <= '0;
            sumSq_q  <= '0;
            mean_q   <= '0;
            msqAvg_q <= '0;
            msq_q    <= '0;
            diff_q   <= '0;
            sq_q     <= '0;
            dv_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            sumSq_q  <= sumSq_d;
            mean_q   <= mean_d;
            msqAvg_q <= msqAvg_d;
            msq_q    <= msq_d;
            diff_q   <= diff_d;
            sq_q     <= sq_d;
            dv_q     <= dv_d;
        end
    end

    assign dv_o = dv_q;
    assign sq_o = sq_q;

endmodule

// File: tb/tb_mfcc_var_acc.sv
// Scoreboard bench for mfcc_var_acc: a longint model pushes the expected variance when a window completes.
module tb_mfcc_var_acc;

    logic        clk;
    logic        rst_n;
    logic        dv_i;
    logic [15:0] x_i;
    logic        ready_o;
    logic        dv_o;
    logic [31:0] sq_o;

    int     nChecks = 0;
    int     nPass   = 0;
    longint expQ[$];
    longint mSum    = 0;
    longint mSumSq  = 0;
    int     mCnt    = 0;
    int     nExpDv  = 0;
    int     nDv     = 0;
    longint cyc     = 0;
    longint lastDv  = -1;
    bit     periodChk = 0;

    mfcc_var_acc #(.IBIT(16), .OBIT(32), .LOG2N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dv_i    (dv_i),
        .x_i     (x_i),
        .ready_o (ready_o),
        .dv_o    (dv_o),
        .sq_o    (sq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference variance from the window's running sums.
    function automatic longint modelResult(input longint s, input longint ss);
        longint mean, msqAvg, diff, res;
        mean   = s >>> 8;
        msqAvg = ss >>> 8;
        diff   = msqAvg - mean * mean;
        if (diff < 0) diff = 0;
        res = diff >>> 10;
`ifdef MIN_VAR_CLAMP_EN
        if (res < 1024) res = 1024;
`endif
        return res;
    endfunction

    task automatic applyStimulus(input int x);
        dv_i = 1'b1;
        x_i  = x[15:0];
        @(posedge clk);
        #1;
        mSum   += longint'(x);
        mSumSq += longint'(x) * longint'(x);
        mCnt++;
        if (mCnt == 256) begin
            expQ.push_back(modelResult(mSum, mSumSq));
            nExpDv++;
            mSum   = 0;
            mSumSq = 0;
            mCnt   = 0;
        end
    endtask

    // Four busy cycles with junk offered on dv_i; none of it may be taken.
    task automatic applyGap();
        for (int k = 0; k < 4; k++) begin
            dv_i = 1'b1;
            x_i  = 16'd30000;
            checkOutput("ready_low", longint'(ready_o), 0);
            @(posedge clk);
            #1;
        end
        checkOutput("ready_back", longint'(ready_o), 1);
    endtask

    task automatic runWindow(input int kind, input int amp);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                0:       applyStimulus(amp);
                1:       applyStimulus((i % 2 == 0) ? amp : -amp);
                default: applyStimulus(int'($urandom_range(0, 40000)) - 17000);
            endcase
        end
        applyGap();
    endtask

    always @(negedge clk) begin
        if (dv_o === 1'b1) begin
            nDv++;
            checkOutput("ready_with_dv", longint'(ready_o), 1);
            checkOutput("sq_hi_bits", longint'(sq_o[31:21]), 0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_dv", 1, 0);
            end else begin
                checkOutput("sq_value", longint'(sq_o), expQ.pop_front());
            end
            if (periodChk && lastDv >= 0) begin
                checkOutput("dv_period", cyc - lastDv, 260);
            end
            lastDv = cyc;
        end
    end

    initial begin
        rst_n = 1'b0;
        dv_i  = 1'b0;
        x_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", longint'(ready_o), 1);
        checkOutput("rst_dv", longint'(dv_o), 0);
        checkOutput("rst_sq", longint'(sq_o), 0);
        rst_n = 1'b1;

        runWindow(0, 1024);
        runWindow(1, 1024);
        runWindow(1, 2048);
        runWindow(1, 32767);
        runWindow(2, 0);

        // Continuous dv_i, back-to-back windows: fixed period between results.
        lastDv    = -1;
        periodChk = 1;
        runWindow(1, 1024);
        runWindow(1, 1024);
        runWindow(1, 1024);
        periodChk = 0;

        // Abort mid-window; reset must win over dv_i on the same edge.
        for (int i = 0; i < 100; i++) applyStimulus(5000);
        rst_n = 1'b0;
        dv_i  = 1'b1;
        x_i   = 16'd5000;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mSum   = 0;
        mSumSq = 0;
        mCnt   = 0;
        runWindow(1, 1024);

        // Abort while the square is being computed.
        for (int i = 0; i < 256; i++) applyStimulus((i % 2 == 0) ? 2048 : -2048);
        dv_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_sq_ready", longint'(ready_o), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        void'(expQ.pop_back());
        nExpDv--;
        checkOutput("abort_dv", longint'(dv_o), 0);
        checkOutput("abort_sq", longint'(sq_o), 0);
        checkOutput("abort_ready", longint'(ready_o), 1);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        runWindow(1, 2048);

        dv_i = 1'b0;
        for (int t = 0; t < 20 && expQ.size() != 0; t++) @(posedge clk);
        #1;
        checkOutput("drain_queue", longint'(expQ.size()), 0);
        checkOutput("dv_count", longint'(nDv), longint'(nExpDv));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
